// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drain over valid/ready with load forwarding and fence.
// Define SB_FWD_EN to forward loads from pending stores; otherwise loads stall until the buffer is empty.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [DW-1:0]            cpu_wdata,
    output logic                     cpu_stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic                     mem_valid,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-3:0] word_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          empty, full, push, pop, load_stall;
    logic          unused_addr;

    // Byte offset is irrelevant: entries are word-granular.
    assign unused_addr = ^cpu_addr[1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign count = wr_ptr - rd_ptr;

    assign push = cpu_we && !full && (state == IDLE);
    assign pop  = mem_valid && mem_ready;

    assign mem_valid = !empty;
    assign mem_addr  = {word_q[rd_ptr[IW-1:0]], 2'b00};
    assign mem_wdata = data_q[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                word_q[wr_ptr[IW-1:0]] <= cpu_addr[AW-1:2];
                data_q[wr_ptr[IW-1:0]] <= cpu_wdata;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fence_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (fence_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (count == '0) begin
                    state_next = IDLE;
                    fence_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SB_FWD_EN
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [IW-1:0] idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[IW-1:0] + IW'(i);
            if ((PW'(i) < count) && (word_q[idx] == cpu_addr[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
        fwd_hit  = cpu_re && hit;
        fwd_data = (cpu_re && hit) ? hit_data : '0;
    end

    assign load_stall = 1'b0;
`else
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign load_stall = cpu_re && !empty;
`endif

    assign cpu_stall = (cpu_we && full) || (state == DRAIN) || load_stall;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit).
// Expectations adapt to whether SB_FWD_EN is defined.
module tb_store_buffer;
`ifdef SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_we, cpu_re, fence_req, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, fwd_hit, fence_done, mem_valid;
    logic [31:0] fwd_data, mem_addr, mem_wdata;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fence_req(fence_req), .fence_done(fence_done),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        stall;
        logic        valid;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [2:0]  cnt;
        logic        hit;
        logic [31:0] fdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic we, re, input logic [31:0] addr, wdata, input logic rdy,
        input logic stall, valid, input logic [31:0] maddr, mdata,
        input logic [2:0] cnt, input logic hit, input logic [31:0] fdata);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
        v.stall = stall; v.valid = valid; v.maddr = maddr; v.mdata = mdata;
        v.cnt = cnt; v.hit = hit; v.fdata = fdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_we = 0; cpu_re = 0; fence_req = 0; mem_ready = 0;
        cpu_addr = '0; cpu_wdata = '0;
        #1;
        chk("reset mem_valid", 32'(mem_valid), 0);
        chk("reset count", 32'(count), 0);
        chk("reset stall", 32'(cpu_stall), 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset fence_done", 32'(fence_done), 0);
        chk("reset fwd", {fwd_data[30:0], fwd_hit}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full / backpressure
        vecs.push_back(mk(1,0,32'h100,32'hA0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,32'h104,32'hA1,0, 0,1,32'h100,32'hA0,1, 0,0));
        vecs.push_back(mk(1,0,32'h108,32'hA2,0, 0,1,32'h100,32'hA0,2, 0,0));
        vecs.push_back(mk(1,0,32'h10C,32'hA3,0, 0,1,32'h100,32'hA0,3, 0,0));
        vecs.push_back(mk(1,0,32'h110,32'hA4,0, 1,1,32'h100,32'hA0,4, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h100,32'hA0,4, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h104,32'hA1,3, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h108,32'hA2,2, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h10C,32'hA3,1, 0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));
        // Handshake stability, ready pattern 0,0,1,0,1
        vecs.push_back(mk(1,0,32'h20,32'h11111111,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,32'h24,32'h22222222,0, 0,1,32'h20,32'h11111111,1, 0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h20,32'h11111111,2, 0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h20,32'h11111111,2, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h20,32'h11111111,2, 0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h24,32'h22222222,1, 0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,1,32'h24,32'h22222222,1, 0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));
        // Forwarding: youngest wins, miss gives 0, head being popped still matches
        vecs.push_back(mk(1,0,32'h200,32'hAAAA,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,32'h202,32'hBBBB,0, 0,1,32'h200,32'hAAAA,1, 0,0));
        vecs.push_back(mk(0,1,32'h202,0,0, 0,1,32'h200,32'hAAAA,2, 1,32'hBBBB));
        vecs.push_back(mk(0,1,32'h204,0,0, 0,1,32'h200,32'hAAAA,2, 0,0));
        vecs.push_back(mk(0,1,32'h201,0,1, 0,1,32'h200,32'hAAAA,2, 1,32'hBBBB));
        vecs.push_back(mk(0,1,32'h200,0,1, 0,1,32'h200,32'hBBBB,1, 1,32'hBBBB));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));
        // Load with two stores queued and ready high
        vecs.push_back(mk(1,0,32'h300,32'hC0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,32'h304,32'hC1,0, 0,1,32'h300,32'hC0,1, 0,0));
        vecs.push_back(mk(0,1,32'h400,0,1, 0,1,32'h300,32'hC0,2, 0,0));
        vecs.push_back(mk(0,1,32'h400,0,1, 0,1,32'h304,32'hC1,1, 0,0));
        vecs.push_back(mk(0,1,32'h400,0,1, 0,0,0,0,0, 0,0));
        // Store not forwarded in its push cycle
        vecs.push_back(mk(1,1,32'h700,32'hD0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,32'h700,0,1, 0,1,32'h700,32'hD0,1, 1,32'hD0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));

        foreach (vecs[i]) begin
            logic        es;
            logic        eh;
            logic [31:0] ef;
            cpu_we = vecs[i].we; cpu_re = vecs[i].re;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            mem_ready = vecs[i].rdy;
            es = vecs[i].stall | (!FWD && vecs[i].re && vecs[i].valid);
            eh = FWD ? vecs[i].hit : 1'b0;
            ef = FWD ? vecs[i].fdata : 32'h0;
            @(negedge clk);
            chk($sformatf("v%0d stall", i), 32'(cpu_stall), 32'(es));
            chk($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d fwd_hit", i), 32'(fwd_hit), 32'(eh));
            chk($sformatf("v%0d fwd_data", i), fwd_data, ef);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mdata);
            end
            tick();
        end
        cpu_we = 0; cpu_re = 0; mem_ready = 0;

        // Fence with three entries; stores during drain are blocked
        push(32'h800, 32'hF0);
        push(32'h804, 32'hF1);
        push(32'h808, 32'hF2);
        fence_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("fence req stall", 32'(cpu_stall), 0);
        chk("fence req count", 32'(count), 3);
        tick();
        fence_req = 1'b0;
        cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d stall", k), 32'(cpu_stall), 1);
            chk($sformatf("drain%0d count", k), 32'(count), 32'(2 - k));
            chk($sformatf("drain%0d fence_done", k), 32'(fence_done), 32'(k == 2));
            tick();
        end
        cpu_we = 1'b0;
        @(negedge clk);
        chk("post drain stall", 32'(cpu_stall), 0);
        chk("post drain fence_done", 32'(fence_done), 0);
        chk("post drain count", 32'(count), 0);
        tick();

        // Fence on an empty buffer
        fence_req = 1'b1;
        @(negedge clk);
        chk("empty fence done early", 32'(fence_done), 0);
        tick();
        fence_req = 1'b0;
        @(negedge clk);
        chk("empty fence done", 32'(fence_done), 1);
        chk("empty fence stall", 32'(cpu_stall), 1);
        tick();
        @(negedge clk);
        chk("empty fence after", {30'b0, fence_done, cpu_stall}, 0);
        tick();

        // Reset mid-cycle with a pending handshake
        mem_ready = 1'b0;
        push(32'h900, 32'h90);
        push(32'h904, 32'h91);
        push(32'h908, 32'h92);
        @(negedge clk);
        chk("pre reset count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset mem_valid", 32'(mem_valid), 0);
        chk("async reset count", 32'(count), 0);
        chk("async reset stall", 32'(cpu_stall), 0);
        chk("async reset mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push(32'h600, 32'hE0);
        @(negedge clk);
        chk("after reset mem_valid", 32'(mem_valid), 1);
        chk("after reset mem_addr", mem_addr, 32'h600);
        chk("after reset mem_wdata", mem_wdata, 32'hE0);
        chk("after reset count", 32'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
